// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder: mnemonic enum, opcode/funct/rt/CP0 codes.
// Latency: n/a (constants and a pure combinational encode function).
// Backpressure: n/a.
package instr_encoder_pkg;

  typedef enum logic [5:0] {
    ENC_ADDU, ENC_SUBU, ENC_ADD, ENC_SUB, ENC_AND, ENC_OR, ENC_XOR, ENC_NOR, ENC_SLT, ENC_SLTU,
    ENC_SLL, ENC_SRL, ENC_SRA, ENC_SLLV, ENC_SRLV, ENC_SRAV,
    ENC_MULT, ENC_MULTU, ENC_DIV, ENC_DIVU, ENC_MFHI, ENC_MFLO, ENC_MTHI, ENC_MTLO, ENC_JR, ENC_JALR,
    ENC_ADDI, ENC_ADDIU, ENC_ANDI, ENC_ORI, ENC_XORI, ENC_SLTI, ENC_SLTIU, ENC_LUI,
    ENC_LW, ENC_LH, ENC_LHU, ENC_LB, ENC_LBU, ENC_SW, ENC_SH, ENC_SB,
    ENC_BEQ, ENC_BNE, ENC_BLEZ, ENC_BGTZ, ENC_BGEZ, ENC_BLTZ, ENC_J, ENC_JAL,
    ENC_MFC0, ENC_MTC0, ENC_ERET, ENC_NOP
  } enc_op_e;

  // Any req_op at or above this index is not a mnemonic.
  localparam logic [5:0] ENC_COUNT = 6'd54;

  localparam logic [5:0] op_special = 6'h00, op_regimm = 6'h01, op_j = 6'h02, op_jal = 6'h03;
  localparam logic [5:0] op_beq = 6'h04, op_bne = 6'h05, op_blez = 6'h06, op_bgtz = 6'h07;
  localparam logic [5:0] op_addi = 6'h08, op_addiu = 6'h09, op_slti = 6'h0a, op_sltiu = 6'h0b;
  localparam logic [5:0] op_andi = 6'h0c, op_ori = 6'h0d, op_xori = 6'h0e, op_lui = 6'h0f;
  localparam logic [5:0] op_cop0 = 6'h10;
  localparam logic [5:0] op_lb = 6'h20, op_lh = 6'h21, op_lw = 6'h23, op_lbu = 6'h24, op_lhu = 6'h25;
  localparam logic [5:0] op_sb = 6'h28, op_sh = 6'h29, op_sw = 6'h2b;

  localparam logic [5:0] funct_sll = 6'h00, funct_srl = 6'h02, funct_sra = 6'h03;
  localparam logic [5:0] funct_sllv = 6'h04, funct_srlv = 6'h06, funct_srav = 6'h07;
  localparam logic [5:0] funct_jr = 6'h08, funct_jalr = 6'h09, funct_eret = 6'h18;
  localparam logic [5:0] funct_mfhi = 6'h10, funct_mthi = 6'h11, funct_mflo = 6'h12, funct_mtlo = 6'h13;
  localparam logic [5:0] funct_mult = 6'h18, funct_multu = 6'h19, funct_div = 6'h1a, funct_divu = 6'h1b;
  localparam logic [5:0] funct_add = 6'h20, funct_addu = 6'h21, funct_sub = 6'h22, funct_subu = 6'h23;
  localparam logic [5:0] funct_and = 6'h24, funct_or = 6'h25, funct_xor = 6'h26, funct_nor = 6'h27;
  localparam logic [5:0] funct_slt = 6'h2a, funct_sltu = 6'h2b;

  localparam logic [4:0] rt_bltz = 5'b00000, rt_bgez = 5'b00001;
  // CP0 sub-ops live in the rs field of op_cop0.
  localparam logic [4:0] rs_mfc0 = 5'b00000, rs_mtc0 = 5'b00100, rs_co = 5'b10000;

  // FIFO payload: encoded word plus the address it was allocated.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } fifo_entry_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {op_special, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Every field an op does not use is driven as zero, regardless of the request.
  function automatic logic [31:0] enc_word(input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                                           input logic [25:0] imm);
    case (op)
      ENC_ADDU:  enc_word = r_word(rs, rt, rd, 5'd0, funct_addu);
      ENC_SUBU:  enc_word = r_word(rs, rt, rd, 5'd0, funct_subu);
      ENC_ADD:   enc_word = r_word(rs, rt, rd, 5'd0, funct_add);
      ENC_SUB:   enc_word = r_word(rs, rt, rd, 5'd0, funct_sub);
      ENC_AND:   enc_word = r_word(rs, rt, rd, 5'd0, funct_and);
      ENC_OR:    enc_word = r_word(rs, rt, rd, 5'd0, funct_or);
      ENC_XOR:   enc_word = r_word(rs, rt, rd, 5'd0, funct_xor);
      ENC_NOR:   enc_word = r_word(rs, rt, rd, 5'd0, funct_nor);
      ENC_SLT:   enc_word = r_word(rs, rt, rd, 5'd0, funct_slt);
      ENC_SLTU:  enc_word = r_word(rs, rt, rd, 5'd0, funct_sltu);
      ENC_SLL:   enc_word = r_word(5'd0, rt, rd, sh, funct_sll);
      ENC_SRL:   enc_word = r_word(5'd0, rt, rd, sh, funct_srl);
      ENC_SRA:   enc_word = r_word(5'd0, rt, rd, sh, funct_sra);
      ENC_SLLV:  enc_word = r_word(rs, rt, rd, 5'd0, funct_sllv);
      ENC_SRLV:  enc_word = r_word(rs, rt, rd, 5'd0, funct_srlv);
      ENC_SRAV:  enc_word = r_word(rs, rt, rd, 5'd0, funct_srav);
      ENC_MULT:  enc_word = r_word(rs, rt, 5'd0, 5'd0, funct_mult);
      ENC_MULTU: enc_word = r_word(rs, rt, 5'd0, 5'd0, funct_multu);
      ENC_DIV:   enc_word = r_word(rs, rt, 5'd0, 5'd0, funct_div);
      ENC_DIVU:  enc_word = r_word(rs, rt, 5'd0, 5'd0, funct_divu);
      ENC_MFHI:  enc_word = r_word(5'd0, 5'd0, rd, 5'd0, funct_mfhi);
      ENC_MFLO:  enc_word = r_word(5'd0, 5'd0, rd, 5'd0, funct_mflo);
      ENC_MTHI:  enc_word = r_word(rs, 5'd0, 5'd0, 5'd0, funct_mthi);
      ENC_MTLO:  enc_word = r_word(rs, 5'd0, 5'd0, 5'd0, funct_mtlo);
      ENC_JR:    enc_word = r_word(rs, 5'd0, 5'd0, 5'd0, funct_jr);
      ENC_JALR:  enc_word = r_word(rs, 5'd0, rd, 5'd0, funct_jalr);
      ENC_ADDI:  enc_word = i_word(op_addi, rs, rt, imm[15:0]);
      ENC_ADDIU: enc_word = i_word(op_addiu, rs, rt, imm[15:0]);
      ENC_ANDI:  enc_word = i_word(op_andi, rs, rt, imm[15:0]);
      ENC_ORI:   enc_word = i_word(op_ori, rs, rt, imm[15:0]);
      ENC_XORI:  enc_word = i_word(op_xori, rs, rt, imm[15:0]);
      ENC_SLTI:  enc_word = i_word(op_slti, rs, rt, imm[15:0]);
      ENC_SLTIU: enc_word = i_word(op_sltiu, rs, rt, imm[15:0]);
      ENC_LUI:   enc_word = i_word(op_lui, 5'd0, rt, imm[15:0]);
      ENC_LW:    enc_word = i_word(op_lw, rs, rt, imm[15:0]);
      ENC_LH:    enc_word = i_word(op_lh, rs, rt, imm[15:0]);
      ENC_LHU:   enc_word = i_word(op_lhu, rs, rt, imm[15:0]);
      ENC_LB:    enc_word = i_word(op_lb, rs, rt, imm[15:0]);
      ENC_LBU:   enc_word = i_word(op_lbu, rs, rt, imm[15:0]);
      ENC_SW:    enc_word = i_word(op_sw, rs, rt, imm[15:0]);
      ENC_SH:    enc_word = i_word(op_sh, rs, rt, imm[15:0]);
      ENC_SB:    enc_word = i_word(op_sb, rs, rt, imm[15:0]);
      ENC_BEQ:   enc_word = i_word(op_beq, rs, rt, imm[15:0]);
      ENC_BNE:   enc_word = i_word(op_bne, rs, rt, imm[15:0]);
      ENC_BLEZ:  enc_word = i_word(op_blez, rs, 5'd0, imm[15:0]);
      ENC_BGTZ:  enc_word = i_word(op_bgtz, rs, 5'd0, imm[15:0]);
      ENC_BGEZ:  enc_word = i_word(op_regimm, rs, rt_bgez, imm[15:0]);
      ENC_BLTZ:  enc_word = i_word(op_regimm, rs, rt_bltz, imm[15:0]);
      ENC_J:     enc_word = {op_j, imm};
      ENC_JAL:   enc_word = {op_jal, imm};
      ENC_MFC0:  enc_word = {op_cop0, rs_mfc0, rt, rd, 11'd0};
      ENC_MTC0:  enc_word = {op_cop0, rs_mtc0, rt, rd, 11'd0};
      ENC_ERET:  enc_word = {op_cop0, rs_co, 15'd0, funct_eret};
      default:   enc_word = 32'h0;  // nop, and invalid indices (never pushed)
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle between an instruction source and the encoder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the output side.
// slave = encoder side; master = request producer / word consumer side.
interface instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [4:0]  req_shamt;
  logic [25:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [15:0] words;

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, out_ready,
    output req_ready, out_valid, out_instr, out_addr, err, words
  );

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, out_ready,
    input  req_ready, out_valid, out_instr, out_addr, err, words
  );
endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// Generic synchronous FIFO with full/empty/count and a synchronous flush.
// Latency: a push is visible at pop_data the cycle after the push edge (no bypass).
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, reset, flush, push/push_data, pop/pop_data, full, empty, count.
module instr_encoder_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic instruction requests into MIPS words tagged with sequential addresses.
// Latency: accepted request appears at the output the next cycle when the FIFO was empty.
// Backpressure: req_ready drops while the FIFO is full (no pass-through) or during restart.
// Ports: clk, reset (sync, high), restart (flush + address reload), bus (slave modport).
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           restart,
  instr_encoder_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  fifo_entry_t    push_ent, head_ent;
  logic           full, empty, accept, op_ok, push, pop;
  logic [CW-1:0]  count;
  logic [31:0]    alloc_addr;
  logic           err_q;
  logic [15:0]    words_q;

  assign op_ok  = (bus.req_op < ENC_COUNT);
  assign bus.req_ready = (count < CW'(DEPTH)) && !restart;
  assign accept = bus.req_valid && bus.req_ready;
  // Invalid ops are accepted and dropped so they never consume an address.
  assign push   = accept && op_ok && !full;
  assign pop    = bus.out_ready && !empty;

  assign push_ent = '{
    instr: enc_word(bus.req_op, bus.req_rs, bus.req_rt, bus.req_rd, bus.req_shamt, bus.req_imm),
    addr:  alloc_addr
  };

  instr_encoder_sync_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (restart),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .pop_data  (head_ent),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // When empty, present zero data and the next address to be allocated.
  assign bus.out_valid = !empty;
  assign bus.out_instr = empty ? 32'h0 : head_ent.instr;
  assign bus.out_addr  = empty ? alloc_addr : head_ent.addr;
  assign bus.err       = err_q;
  assign bus.words     = words_q;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      alloc_addr <= BASE_ADDR;
      words_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) alloc_addr <= alloc_addr + 32'd4;
      if (pop && (words_q != 16'hFFFF)) words_q <= words_q + 16'd1;
      err_q <= accept && !op_ok;
    end
  end
endmodule
